sarray_spm_bridge: RTL and testbench

Scratchpad-side responder that sits directly downstream of sarray_top's memory channels. It accepts read requests (ar) and returns read data (r), and it accepts writes (aw). Both are served from one single-port synchronous SRAM macro with a fixed read latency. A credit-limited response FIFO guarantees that no read data is lost when the systolic array applies r backpressure.

---
 rtl/sarray_spm_bridge.sv | 146 ++++++++++++++
 tb/tb_sarray_spm_bridge.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sarray_spm_bridge.sv
// Scratchpad responder for sarray: arbitrates ar/aw onto one single-port SRAM and returns
// read data through a credit-limited FIFO so r backpressure never loses a beat.
module sarray_spm_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sarray_ar_valid_i,
  output logic                     sarray_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]    sarray_ar_addr_i,
  output logic                     sarray_r_valid_o,
  input  logic                     sarray_r_ready_i,
  output logic [DATA_WIDTH-1:0]    sarray_r_data_o,
  input  logic                     sarray_aw_valid_i,
  output logic                     sarray_aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]    sarray_aw_addr_i,
  input  logic [DATA_WIDTH-1:0]    sarray_aw_data_i,
  output logic                     sram_en_o,
  output logic                     sram_we_o,
  output logic [$clog2(DEPTH)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]    sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]    sram_rdata_i,
  output logic                     idle_o
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned OffW = $clog2(DATA_WIDTH / 8);
  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {GntRead = 1'b0, GntWrite = 1'b1} gnt_e;

  gnt_e                  last_grant_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RD_LAT-1:0]     pipe_q;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       occ_q, occ_d;

  logic                  rd_elig, wr_elig, rd_gnt, wr_gnt;
  logic                  rd_stage, push, pop;
  logic [ADDR_WIDTH-1:0] ar_word, aw_word;
  logic                  unused_word_bits;

  // Byte offset is dropped and indices above DEPTH wrap by truncation.
  assign ar_word          = sarray_ar_addr_i >> OffW;
  assign aw_word          = sarray_aw_addr_i >> OffW;
  assign unused_word_bits = ^{ar_word[ADDR_WIDTH-1:IdxW], aw_word[ADDR_WIDTH-1:IdxW]};

  assign rd_elig = sarray_ar_valid_i && (cnt_q < CntW'(RSP_DEPTH));
  assign wr_elig = sarray_aw_valid_i;

  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (!rst) begin
      if (rd_elig && wr_elig) begin
        wr_gnt = (last_grant_q == GntRead);
        rd_gnt = (last_grant_q == GntWrite);
      end else begin
        rd_gnt = rd_elig;
        wr_gnt = wr_elig;
      end
    end
  end

  assign sarray_ar_ready_o = rd_gnt;
  assign sarray_aw_ready_o = wr_gnt;

  assign rd_stage = sram_en_o && !sram_we_o;
  assign push     = pipe_q[RD_LAT-1];
  assign pop      = sarray_r_valid_o && sarray_r_ready_i;

  assign sarray_r_valid_o = (occ_q != '0);
  assign sarray_r_data_o  = fifo_q[rd_ptr_q];
  assign idle_o           = (cnt_q == '0) && !sram_en_o;

  // Credit covers a read from acceptance until its beat leaves the FIFO.
  always_comb begin
    cnt_d = cnt_q;
    if (rd_gnt && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!rd_gnt && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + CntW'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GntRead;
      cnt_q        <= '0;
      pipe_q       <= '0;
      sram_en_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
    end else begin
      if (rd_elig && wr_elig) begin
        last_grant_q <= wr_gnt ? GntWrite : GntRead;
      end
      cnt_q     <= cnt_d;
      pipe_q    <= (pipe_q << 1) | RD_LAT'(rd_stage);
      sram_en_o <= rd_gnt || wr_gnt;
      sram_we_o <= wr_gnt;
      if (wr_gnt) begin
        sram_addr_o  <= aw_word[IdxW-1:0];
        sram_wdata_o <= sarray_aw_data_i;
      end else if (rd_gnt) begin
        sram_addr_o <= ar_word[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sram_rdata_i;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_sarray_spm_bridge.sv
// Directed bench for sarray_spm_bridge: a default instance (RD_LAT=1, RSP_DEPTH=4) and a
// streaming instance (RD_LAT=2, RSP_DEPTH=8), each backed by a behavioural SRAM.
module tb_sarray_spm_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready, en, we, idle;
  logic [31:0]  ar_addr, aw_addr;
  logic [127:0] r_data, aw_data, wdata, rdata;
  logic [9:0]   saddr;

  logic         b_ar_valid, b_ar_ready, b_r_valid, b_r_ready, b_aw_valid, b_aw_ready;
  logic         b_en, b_we, b_idle;
  logic [31:0]  b_ar_addr, b_aw_addr;
  logic [127:0] b_r_data, b_aw_data, b_wdata, b_rdata;
  logic [9:0]   b_saddr;

  sarray_spm_bridge dut (
    .clk(clk), .rst(rst),
    .sarray_ar_valid_i(ar_valid), .sarray_ar_ready_o(ar_ready), .sarray_ar_addr_i(ar_addr),
    .sarray_r_valid_o(r_valid), .sarray_r_ready_i(r_ready), .sarray_r_data_o(r_data),
    .sarray_aw_valid_i(aw_valid), .sarray_aw_ready_o(aw_ready), .sarray_aw_addr_i(aw_addr),
    .sarray_aw_data_i(aw_data), .sram_en_o(en), .sram_we_o(we), .sram_addr_o(saddr),
    .sram_wdata_o(wdata), .sram_rdata_i(rdata), .idle_o(idle)
  );

  sarray_spm_bridge #(.RD_LAT(2), .RSP_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst),
    .sarray_ar_valid_i(b_ar_valid), .sarray_ar_ready_o(b_ar_ready),
    .sarray_ar_addr_i(b_ar_addr), .sarray_r_valid_o(b_r_valid), .sarray_r_ready_i(b_r_ready),
    .sarray_r_data_o(b_r_data), .sarray_aw_valid_i(b_aw_valid),
    .sarray_aw_ready_o(b_aw_ready), .sarray_aw_addr_i(b_aw_addr),
    .sarray_aw_data_i(b_aw_data), .sram_en_o(b_en), .sram_we_o(b_we), .sram_addr_o(b_saddr),
    .sram_wdata_o(b_wdata), .sram_rdata_i(b_rdata), .idle_o(b_idle)
  );

  // Behavioural SRAMs: latency 1 for dut, latency 2 for dut_b.
  logic [127:0] mem_a [1024];
  logic [127:0] rd_a_q;
  always @(posedge clk) begin
    if (en) begin
      if (we) mem_a[saddr] <= wdata;
      else    rd_a_q <= mem_a[saddr];
    end
  end
  assign rdata = rd_a_q;

  logic [127:0] mem_b [1024];
  logic [127:0] rd_b1_q, rd_b2_q;
  always @(posedge clk) begin
    if (b_en) begin
      if (b_we) mem_b[b_saddr] <= b_wdata;
      else      rd_b1_q <= mem_b[b_saddr];
    end
    rd_b2_q <= rd_b1_q;
  end
  assign b_rdata = rd_b2_q;

  typedef struct {
    logic [31:0]  w_addr;
    logic [127:0] w_data;
    logic [31:0]  r_addr;
    logic [9:0]   idx;
  } vec_t;
  vec_t vecs [6];

  int n_vec = 0;
  int n_err = 0;
  int lat, issued, got, stalls, gaps, extra;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [127:0] word_a(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] word_b(input int i);
    return {4{32'hB000_0000 + 32'(i)}};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_4008, {4{32'h1111_0001}}, 32'h0000_0000, 10'd0};
    vecs[1] = '{32'h0000_0010, {4{32'h2222_0002}}, 32'h0000_001F, 10'd1};
    vecs[2] = '{32'h0000_3FF0, {4{32'h3333_0003}}, 32'h0000_7FF0, 10'd1023};
    vecs[3] = '{32'hFFFF_FFF0, {4{32'h4444_0004}}, 32'h0000_3FF0, 10'd1023};
    vecs[4] = '{32'h0000_1230, {4{32'h5555_0005}}, 32'h0000_1234, 10'd291};
    vecs[5] = '{32'h0000_0020, {4{32'h6666_0006}}, 32'h0000_0020, 10'd2};

    rst = 1'b1;
    ar_valid = 1'b1; aw_valid = 1'b1; r_ready = 1'b0;
    ar_addr = '0; aw_addr = '0; aw_data = '0;
    b_ar_valid = 1'b0; b_aw_valid = 1'b0; b_r_ready = 1'b0;
    b_ar_addr = '0; b_aw_addr = '0; b_aw_data = '0;
    tick();
    mid();
    chk("rst_ar_ready", ar_ready, 1'b0);
    chk("rst_aw_ready", aw_ready, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_data", r_data, '0);
    chk("rst_sram_en", en, 1'b0);
    chk("rst_sram_we", we, 1'b0);
    chk("rst_sram_addr", saddr, '0);
    chk("rst_sram_wdata", wdata, '0);
    chk("rst_idle", idle, 1'b1);
    tick();
    rst = 1'b0; ar_valid = 1'b0; aw_valid = 1'b0;
    tick();

    // Write then read of the same word on consecutive cycles.
    r_ready = 1'b1;
    aw_valid = 1'b1; aw_addr = 32'h40; aw_data = {16{8'hA5}};
    mid();
    chk("raw_aw_ready", aw_ready, 1'b1);
    chk("raw_ar_idle", ar_ready, 1'b0);
    tick();
    aw_valid = 1'b0; ar_valid = 1'b1; ar_addr = 32'h40;
    mid();
    chk("raw_wr_en", en, 1'b1);
    chk("raw_wr_we", we, 1'b1);
    chk("raw_wr_addr", saddr, 10'd4);
    chk("raw_wr_data", wdata, {16{8'hA5}});
    chk("raw_ar_ready", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
    mid();
    chk("raw_rd_en", en, 1'b1);
    chk("raw_rd_we", we, 1'b0);
    chk("raw_rd_addr", saddr, 10'd4);
    chk("raw_t2_valid", r_valid, 1'b0);
    tick();
    mid();
    chk("raw_t3_valid", r_valid, 1'b0);
    tick();
    mid();
    chk("raw_t4_valid", r_valid, 1'b1);
    chk("raw_t4_data", r_data, {16{8'hA5}});
    tick();
    mid();
    chk("raw_t5_valid", r_valid, 1'b0);
    chk("raw_t5_idle", idle, 1'b1);
    tick();

    // Table: address mapping, wrap and offset, each as a write followed by a read.
    for (int k = 0; k < 6; k++) begin
      aw_valid = 1'b1; aw_addr = vecs[k].w_addr; aw_data = vecs[k].w_data;
      mid();
      chk($sformatf("vec%0d_aw_ready", k), aw_ready, 1'b1);
      tick();
      aw_valid = 1'b0; ar_valid = 1'b1; ar_addr = vecs[k].r_addr;
      mid();
      chk($sformatf("vec%0d_wr_idx", k), saddr, vecs[k].idx);
      chk($sformatf("vec%0d_ar_ready", k), ar_ready, 1'b1);
      tick();
      ar_valid = 1'b0;
      mid();
      chk($sformatf("vec%0d_rd_idx", k), saddr, vecs[k].idx);
      lat = 1;
      while (!r_valid && lat < 10) begin
        tick();
        mid();
        lat++;
      end
      chk($sformatf("vec%0d_latency", k), lat, 3);
      chk($sformatf("vec%0d_rdata", k), r_data, vecs[k].w_data);
      tick();
    end

    // Backpressure: only RSP_DEPTH reads accepted while r_ready is low.
    for (int i = 0; i < 6; i++) begin
      aw_valid = 1'b1; aw_addr = 32'(i * 16); aw_data = word_a(i);
      tick();
    end
    aw_valid = 1'b0;
    r_ready = 1'b0;
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      ar_valid = (issued < 5); ar_addr = 32'(issued * 16);
      mid();
      if (ar_valid && ar_ready) issued++;
      tick();
    end
    chk("bp_accepted", issued, 4);
    mid();
    chk("bp_ar_blocked", ar_ready, 1'b0);
    chk("bp_head_valid", r_valid, 1'b1);
    chk("bp_head_data", r_data, word_a(0));
    tick();
    r_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      ar_valid = (issued < 5); ar_addr = 32'(issued * 16);
      mid();
      if (ar_valid && ar_ready) issued++;
      if (r_valid) begin
        chk($sformatf("bp_order%0d", got), r_data, word_a(got));
        got++;
      end
      tick();
    end
    ar_valid = 1'b0;
    chk("bp_got", got, 5);
    chk("bp_issued", issued, 5);

    // Tie fairness after reset: W,R,W,R,W,R.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ar_valid = 1'b1; aw_valid = 1'b1;
    ar_addr = 32'h100; aw_addr = 32'h100; aw_data = {4{32'h7777_0007}};
    for (int c = 0; c < 6; c++) begin
      mid();
      chk($sformatf("tie%0d_ar", c), ar_ready, 1'((c % 2) == 1));
      chk($sformatf("tie%0d_aw", c), aw_ready, 1'((c % 2) == 0));
      tick();
    end
    ar_valid = 1'b0; aw_valid = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    // Reset with three reads outstanding drops them.
    r_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      ar_valid = 1'b1; ar_addr = 32'(c * 16);
      mid();
      chk($sformatf("mid_rst_ar%0d", c), ar_ready, 1'b1);
      tick();
    end
    ar_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; ar_valid = 1'b1; ar_addr = 32'h50;
    mid();
    chk("mid_rst_r_valid", r_valid, 1'b0);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_ar_ready", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
    lat = 1;
    mid();
    while (!r_valid && lat < 10) begin
      tick();
      mid();
      lat++;
    end
    chk("mid_rst_new_lat", lat, 3);
    chk("mid_rst_new_data", r_data, word_a(5));
    r_ready = 1'b1;
    tick();
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      mid();
      if (r_valid) extra++;
      tick();
    end
    chk("mid_rst_no_stale", extra, 0);

    // Streaming on the RD_LAT=2 instance.
    for (int i = 0; i < 64; i++) begin
      b_aw_valid = 1'b1; b_aw_addr = 32'(i * 16); b_aw_data = word_b(i);
      tick();
    end
    b_aw_valid = 1'b0; b_r_ready = 1'b1;
    issued = 0; got = 0; stalls = 0; gaps = 0;
    for (int c = 0; c < 200 && got < 64; c++) begin
      b_ar_valid = (issued < 64); b_ar_addr = 32'(issued * 16);
      mid();
      if (b_ar_valid) begin
        if (b_ar_ready) issued++;
        else stalls++;
      end
      if (b_r_valid) begin
        chk($sformatf("stream%0d", got), b_r_data, word_b(got));
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      tick();
    end
    b_ar_valid = 1'b0;
    chk("stream_stalls", stalls, 0);
    chk("stream_gaps", gaps, 0);
    chk("stream_count", got, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
